hilo_unit: RTL and testbench
============================

// Module: hilo_unit
// PURPOSE
//  Multi-cycle issuer for the shared mult/div engine, and owner of the architectural HI/LO registers.
//  Accepts MULT/MULTU/DIV/DIVU from the execute stage and drives the engine operands/op from latched regs.
//  Stalls the pipeline while the engine's multicycle path settles, then captures hi/lo into HI/LO.
//  Also serves MTHI/MTLO writes and MFHI/MFLO reads.
// PARAMETERS
//  MUL_LAT  2  cycles from accept to HI/LO write for MULT/MULTU; legal range >= 2
//  DIV_LAT  8  cycles from accept to HI/LO write for DIV/DIVU; legal range >= 2
// PORTS
//  clk        in   1      clock; the only clock
//  resetn     in   1      synchronous active-low reset
//  req_valid  in   1      execute stage presents a mult/div op
//  req_op     in   mult_t MULT, MULTU, DIV or DIVU; any other value = no-op
//  req_a      in   32     rs operand
//  req_b      in   32     rt operand
//  flush      in   1      exception/flush; aborts the in-flight op
//  stall      out  1      hold the pipeline front end
//  eng_a      out  32     latched operand A to engine
//  eng_b      out  32     latched operand B to engine
//  eng_op     out  mult_t latched op to engine
//  eng_hi     in   32     engine hi result
//  eng_lo     in   32     engine lo result
//  hi_we      in   1      MTHI write enable
//  lo_we      in   1      MTLO write enable
//  wdata      in   32     MTHI/MTLO data
//  rd_hi      out  32     HI value for MFHI; bypasses a same-cycle MTHI
//  rd_lo      out  32     LO value for MFLO; bypasses a same-cycle MTLO
// BEHAVIOUR
//  Reset (resetn=0 at posedge):
//   - HI=LO=0; state=IDLE; cnt=0; eng_a=eng_b=0; eng_op=no-op; stall=0.
//   - Reset mid-operation discards the op. No HI/LO write occurs.
//  start = IDLE & req_valid & req_op in {MULT,MULTU,DIV,DIVU} & ~flush.
//  FSM states: IDLE, BUSY.
//   - IDLE --start--> BUSY, on the accept cycle T:
//     - eng_a<=req_a; eng_b<=req_b; eng_op<=req_op.
//     - cnt<=LAT-1, where LAT = MUL_LAT for MULT/MULTU and DIV_LAT for DIV/DIVU.
//   - BUSY: cnt decrements each cycle.
//   - BUSY with cnt==1: HI<=eng_hi, LO<=eng_lo at that edge; next state IDLE.
//   - BUSY & flush: next state IDLE, no HI/LO write, eng_* hold. flush beats completion.
//  stall = start | (BUSY & cnt!=1 & ~flush). Combinational.
//   - stall is 1 for LAT-1 cycles, T..T+LAT-2.
//   - Completion cycle T+LAT-1 has stall=0, so the pipeline advances on the same edge HI/LO is written.
//   - An op still presented in IDLE after completion is a new instruction.
//   - Back-to-back ops: the next op is accepted in cycle T+LAT at the earliest.
//  eng_* hold their last value while IDLE. The engine is combinational; the LAT-1 cycle path is a multicycle constraint.
//  MTHI/MTLO: HI<=wdata if hi_we; LO<=wdata if lo_we; applied in any state.
//   - Completion write beats an MT write to the same register in the same cycle.
//  rd_hi = hi_we ? wdata : HI; rd_lo = lo_we ? wdata : LO.
//  Widths:
//   - MULT/MULTU: 64-bit product, {hi,lo}.
//   - DIV/DIVU: lo=quotient, hi=remainder; signed results truncate toward zero.
//   - Divide by zero: engine outputs are written unchanged. No trap, no special casing.
// TESTING
//  1. MULT a=FFFFFFFD (-3), b=5, MUL_LAT=2 -> stall=1 one cycle; then HI=FFFFFFFF, LO=FFFFFFF1.
//  2. DIV a=7, b=FFFFFFFE (-2), DIV_LAT=8 -> stall=1 seven cycles; then LO=FFFFFFFD, HI=00000001.
//  3. MULTU a=b=FFFFFFFF, then MULTU 2*3 back-to-back -> HI:LO=FFFFFFFE:00000001, then 0:6.
//     - Second op accepted the cycle after the first completes.
//  4. DIVU 100/7 with flush in the 3rd BUSY cycle -> stall drops that cycle; HI/LO keep prior values; state IDLE.
//  5. MTHI wdata=DEADBEEF in IDLE -> rd_hi=DEADBEEF the same cycle; HI=DEADBEEF after the edge.
//     - MTLO coinciding with DIV completion -> LO takes the engine result.
//  6. resetn=0 during BUSY of a DIV -> next cycle HI=LO=0, stall=0, IDLE. DIVU 5/0 -> HI/LO = engine outputs unchanged.

Source files
------------

// File: rtl/hilo_unit.sv
// hilo_unit: multi-cycle issuer for the shared mult/div engine,
// plus the architectural HI/LO registers with MT/MF access.
package hilo_pkg;
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4
  } mult_t;
endpackage

module hilo_unit
  import hilo_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  mult_t       req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] eng_a,
  output logic [31:0] eng_b,
  output mult_t       eng_op,
  input  logic [31:0] eng_hi,
  input  logic [31:0] eng_lo,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] rd_hi,
  output logic [31:0] rd_lo
);

  localparam int LMAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW   = $clog2(LMAX + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic [31:0]   eng_a_q;
  logic [31:0]   eng_b_q;
  mult_t         eng_op_q;

  logic is_md;
  logic is_div;
  logic busy;
  logic last;
  logic start;

  always_comb begin
    is_md  = 1'b0;
    is_div = 1'b0;
    unique case (1'b1)
      (req_op == OP_MULT) || (req_op == OP_MULTU): is_md = 1'b1;
      (req_op == OP_DIV) || (req_op == OP_DIVU): begin
        is_md  = 1'b1;
        is_div = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy  = (state_q == BUSY);
  assign last  = (cnt_q == CW'(1));
  assign start = !busy && req_valid && is_md && !flush;
  assign stall = start || (busy && !last && !flush);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      eng_a_q  <= '0;
      eng_b_q  <= '0;
      eng_op_q <= OP_NONE;
    end else begin
      if (hi_we) hi_q <= wdata;
      if (lo_we) lo_q <= wdata;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= BUSY;
            eng_a_q  <= req_a;
            eng_b_q  <= req_b;
            eng_op_q <= req_op;
            cnt_q    <= is_div ? CW'(DIV_LAT - 1)
                               : CW'(MUL_LAT - 1);
          end
        end
        BUSY: begin
          if (flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (last) begin
            // engine result overrides any same-cycle MT write
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= eng_hi;
            lo_q    <= eng_lo;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
      endcase
    end
  end

  assign eng_a  = eng_a_q;
  assign eng_b  = eng_b_q;
  assign eng_op = eng_op_q;
  assign rd_hi  = hi_we ? wdata : hi_q;
  assign rd_lo  = lo_we ? wdata : lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed + randomized checks of hilo_unit against
// an arithmetic reference of mult/div results and HI/LO state.
module tb_hilo_unit;
  import hilo_pkg::*;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  mult_t       req_op = OP_NONE;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic [31:0] eng_a;
  logic [31:0] eng_b;
  mult_t       eng_op;
  logic [31:0] eng_hi;
  logic [31:0] eng_lo;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rd_hi;
  logic [31:0] rd_lo;

  int n_run = 0;
  int n_fail = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  // architectural result {hi,lo}; div-by-zero gives {a, all-ones}
  function automatic logic [63:0] ref_res(input mult_t op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q = 0;
    r = 0;
    p = 64'h0;
    case (op)
      OP_MULT: begin
        q = sa * sb;
        p = q;
      end
      OP_MULTU: p = {32'h0, a} * {32'h0, b};
      OP_DIV: begin
        if (b == 32'h0) p = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa - q * sb;
          p = {r[31:0], q[31:0]};
        end
      end
      OP_DIVU: begin
        if (b == 32'h0) p = {a, 32'hFFFFFFFF};
        else p = {a % b, a / b};
      end
      default: p = 64'hA5A5A5A5_5A5A5A5A;
    endcase
    return p;
  endfunction

  assign {eng_hi, eng_lo} = ref_res(eng_op, eng_a, eng_b);

  hilo_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .flush(flush),
    .stall(stall),
    .eng_a(eng_a), .eng_b(eng_b), .eng_op(eng_op),
    .eng_hi(eng_hi), .eng_lo(eng_lo),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .rd_hi(rd_hi), .rd_lo(rd_lo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input mult_t op, input logic [31:0] a,
                        input logic [31:0] b, input bit mt_lo,
                        input logic [31:0] mt_val, input string nm);
    int lat, n;
    logic [63:0] ex;
    lat = (op == OP_DIV || op == OP_DIVU) ? DIV_LAT : MUL_LAT;
    ex = ref_res(op, a, b);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    #1;
    n_run++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL %s accept: stall=%b want 1", nm, stall);
    end
    n = 0;
    while (stall === 1'b1 && n < 50) begin
      tick();
      n++;
      if (n == 1) begin
        req_a = ~a;
        req_b = ~b;
        #1;
        n_run++;
        if (eng_a !== a || eng_b !== b || eng_op !== op) begin
          n_fail++;
          $display("FAIL %s latch: eng=%h/%h/%0d want %h/%h/%0d",
                   nm, eng_a, eng_b, eng_op, a, b, op);
        end
      end else begin
        #1;
      end
    end
    n_run++;
    if (n != lat - 1) begin
      n_fail++;
      $display("FAIL %s stall_cycles: got %0d want %0d", nm, n, lat - 1);
    end
    if (mt_lo) begin
      lo_we = 1'b1;
      wdata = mt_val;
      #1;
      n_run++;
      if (rd_lo !== mt_val) begin
        n_fail++;
        $display("FAIL %s mtlo_bypass: rd_lo=%h want %h", nm, rd_lo, mt_val);
      end
    end
    tick();
    lo_we = 1'b0;
    req_valid = 1'b0;
    req_op = OP_NONE;
    #1;
    m_hi = ex[63:32];
    m_lo = ex[31:0];
    n_run++;
    if (rd_hi !== m_hi || rd_lo !== m_lo || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL %s result: hi:lo=%h:%h stall=%b want %h:%h 0",
               nm, rd_hi, rd_lo, stall, m_hi, m_lo);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    #1;
    n_run++;
    if (stall !== 1'b0 || rd_hi !== 32'h0 || rd_lo !== 32'h0 ||
        eng_op !== OP_NONE || eng_a !== 32'h0 || eng_b !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: stall=%b hi=%h lo=%h op=%0d a=%h b=%h want zeros",
               stall, rd_hi, rd_lo, eng_op, eng_a, eng_b);
    end
    m_hi = '0;
    m_lo = '0;
  endtask

  task automatic test_mult();
    run_op(OP_MULT, 32'hFFFFFFFD, 32'd5, 1'b0, '0, "mult");
    n_run++;
    if ({rd_hi, rd_lo} !== 64'hFFFFFFFF_FFFFFFF1) begin
      n_fail++;
      $display("FAIL mult_const: %h:%h want FFFFFFFF:FFFFFFF1", rd_hi, rd_lo);
    end
  endtask

  task automatic test_div();
    run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, 1'b0, '0, "div");
    n_run++;
    if (rd_lo !== 32'hFFFFFFFD || rd_hi !== 32'h1) begin
      n_fail++;
      $display("FAIL div_const: %h:%h want 00000001:FFFFFFFD", rd_hi, rd_lo);
    end
  endtask

  task automatic test_back_to_back();
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, '0, "b2b_1");
    n_run++;
    if ({rd_hi, rd_lo} !== 64'hFFFFFFFE_00000001) begin
      n_fail++;
      $display("FAIL b2b_1_const: %h:%h want FFFFFFFE:00000001", rd_hi, rd_lo);
    end
    run_op(OP_MULTU, 32'd2, 32'd3, 1'b0, '0, "b2b_2");
    n_run++;
    if ({rd_hi, rd_lo} !== 64'h00000000_00000006) begin
      n_fail++;
      $display("FAIL b2b_2_const: %h:%h want 0:6", rd_hi, rd_lo);
    end
  endtask

  task automatic test_flush();
    logic [31:0] ph, pl;
    ph = m_hi;
    pl = m_lo;
    req_valid = 1'b1;
    req_op = OP_DIVU;
    req_a = 32'd100;
    req_b = 32'd7;
    tick();
    tick();
    tick();
    flush = 1'b1;
    #1;
    n_run++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_stall: stall=%b want 0", stall);
    end
    tick();
    flush = 1'b0;
    req_valid = 1'b0;
    req_op = OP_NONE;
    repeat (10) tick();
    n_run++;
    if (stall !== 1'b0 || rd_hi !== ph || rd_lo !== pl || eng_a !== 32'd100) begin
      n_fail++;
      $display("FAIL flush_keep: stall=%b hi:lo=%h:%h eng_a=%h want 0 %h:%h 64",
               stall, rd_hi, rd_lo, eng_a, ph, pl);
    end
    run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, '0, "after_flush");
    // flush on the would-be accept cycle and a non-op are both ignored
    ph = m_hi;
    pl = m_lo;
    req_valid = 1'b1;
    req_op = OP_MULT;
    flush = 1'b1;
    #1;
    n_run++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_accept: stall=%b want 0", stall);
    end
    tick();
    flush = 1'b0;
    req_op = mult_t'(3'd6);
    #1;
    n_run++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL noop_stall: stall=%b want 0", stall);
    end
    repeat (4) tick();
    req_valid = 1'b0;
    req_op = OP_NONE;
    #1;
    n_run++;
    if (stall !== 1'b0 || rd_hi !== ph || rd_lo !== pl) begin
      n_fail++;
      $display("FAIL noop_keep: stall=%b hi:lo=%h:%h want 0 %h:%h",
               stall, rd_hi, rd_lo, ph, pl);
    end
  endtask

  task automatic test_mt();
    hi_we = 1'b1;
    wdata = 32'hDEADBEEF;
    #1;
    n_run++;
    if (rd_hi !== 32'hDEADBEEF || rd_lo !== m_lo) begin
      n_fail++;
      $display("FAIL mthi_bypass: hi:lo=%h:%h want DEADBEEF:%h", rd_hi, rd_lo, m_lo);
    end
    tick();
    hi_we = 1'b0;
    lo_we = 1'b1;
    wdata = 32'h12345678;
    #1;
    m_hi = 32'hDEADBEEF;
    n_run++;
    if (rd_hi !== 32'hDEADBEEF || rd_lo !== 32'h12345678) begin
      n_fail++;
      $display("FAIL mthi_store: hi:lo=%h:%h want DEADBEEF:12345678", rd_hi, rd_lo);
    end
    tick();
    lo_we = 1'b0;
    #1;
    m_lo = 32'h12345678;
    n_run++;
    if (rd_lo !== 32'h12345678) begin
      n_fail++;
      $display("FAIL mtlo_store: lo=%h want 12345678", rd_lo);
    end
    run_op(OP_DIV, 32'hFFFFFF9C, 32'd7, 1'b1, 32'hCAFEF00D, "mtlo_vs_div");
    n_run++;
    if (rd_lo !== 32'hFFFFFFF2 || rd_hi !== 32'hFFFFFFFE) begin
      n_fail++;
      $display("FAIL mtlo_vs_div_const: %h:%h want FFFFFFFE:FFFFFFF2", rd_hi, rd_lo);
    end
  endtask

  task automatic test_reset_busy();
    req_valid = 1'b1;
    req_op = OP_DIV;
    req_a = 32'd7;
    req_b = 32'd3;
    tick();
    tick();
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    req_valid = 1'b0;
    req_op = OP_NONE;
    #1;
    n_run++;
    if (stall !== 1'b0 || rd_hi !== 32'h0 || rd_lo !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_busy: stall=%b hi:lo=%h:%h want 0 0:0", stall, rd_hi, rd_lo);
    end
    repeat (10) tick();
    n_run++;
    if (rd_hi !== 32'h0 || rd_lo !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_nowrite: hi:lo=%h:%h want 0:0", rd_hi, rd_lo);
    end
    m_hi = '0;
    m_lo = '0;
    run_op(OP_DIVU, 32'd5, 32'd0, 1'b0, '0, "divzero");
    n_run++;
    if (rd_hi !== 32'd5 || rd_lo !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL divzero_const: %h:%h want 00000005:FFFFFFFF", rd_hi, rd_lo);
    end
  endtask

  task automatic test_random();
    int k;
    mult_t op;
    logic [31:0] a, b, v;
    bit wh, wl;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 5);
      if (k <= 3) begin
        op = mult_t'(3'(k + 1));
        a = $urandom();
        b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom();
        run_op(op, a, b, 1'($urandom_range(0, 1)), $urandom(), "rand_op");
      end else if (k == 4) begin
        wh = 1'($urandom_range(0, 1));
        wl = !wh || 1'($urandom_range(0, 1));
        v = $urandom();
        hi_we = wh;
        lo_we = wl;
        wdata = v;
        if (wh) m_hi = v;
        if (wl) m_lo = v;
        #1;
        n_run++;
        if (rd_hi !== m_hi || rd_lo !== m_lo) begin
          n_fail++;
          $display("FAIL rand_mt_bypass: %h:%h want %h:%h", rd_hi, rd_lo, m_hi, m_lo);
        end
        tick();
        hi_we = 1'b0;
        lo_we = 1'b0;
        #1;
        n_run++;
        if (rd_hi !== m_hi || rd_lo !== m_lo) begin
          n_fail++;
          $display("FAIL rand_mt_store: %h:%h want %h:%h", rd_hi, rd_lo, m_hi, m_lo);
        end
      end else begin
        repeat ($urandom_range(1, 3)) tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_back_to_back();
    test_flush();
    test_mt();
    test_reset_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
